// File: rtl/du_skid_stage_if.sv
// du_skid_stage_if: valid/ready beat channel carrying WAYS issue ways of DATA_W-bit payload
//   valid : per-way valid of the beat
//   data  : payload, way k in bits [k*DATA_W +: DATA_W]
//   ready : receiver can accept the current beat
//   master drives valid/data, slave drives ready
interface du_skid_stage_if #(
  parameter int WAYS   = 2,
  parameter int DATA_W = 256
);
  logic [WAYS-1:0]        valid;
  logic [WAYS*DATA_W-1:0] data;
  logic                   ready;
  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/du_skid_stage.sv
// du_skid_stage: 2-entry skid buffer between decode and execute with registered ready
//   clk         : clock, all state updates on posedge
//   reset_n     : asynchronous active-low reset
//   flush_i     : drop every held beat and any incoming beat
//   up          : upstream channel from decode (slave; ready is a flop)
//   dn          : downstream channel to execute (master; driven from the main register)
//   occ_o       : entries held (0, 1 or 2)
//   stall_cnt_o : saturating count of cycles the output beat waited on ready
module du_skid_stage #(
  parameter int WAYS   = 2,
  parameter int DATA_W = 256,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                flush_i,
  du_skid_stage_if.slave      up,
  du_skid_stage_if.master     dn,
  output logic [1:0]          occ_o,
  output logic [CNT_W-1:0]    stall_cnt_o
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
  state_t                 state, state_nx;
  logic                   ready_q, up_xfer, dn_xfer, load_main, load_skid, skid_to_main;
  logic [WAYS-1:0]        main_v, skid_v;
  logic [WAYS*DATA_W-1:0] main_d, skid_d;
  assign up.ready = ready_q;
  assign dn.valid = main_v;
  assign dn.data  = main_d;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= EMPTY;
    else          state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      EMPTY:   state_nx = up_xfer ? ONE : EMPTY;
      ONE:     state_nx = (up_xfer && !dn_xfer) ? TWO : (!up_xfer && dn_xfer) ? EMPTY : ONE;
      TWO:     state_nx = dn_xfer ? ONE : TWO;
      default: state_nx = EMPTY;
    endcase
    if (flush_i) state_nx = EMPTY;
  end
  // Both-transfer in ONE reloads main directly so a full-rate stream never touches the skid.
  always_comb begin
    up_xfer      = |up.valid && ready_q;
    dn_xfer      = |main_v && dn.ready;
    load_main    = !flush_i && up_xfer && (state == EMPTY || (state == ONE && dn_xfer));
    load_skid    = !flush_i && up_xfer && state == ONE && !dn_xfer;
    skid_to_main = !flush_i && state == TWO && dn_xfer;
    occ_o        = state;
  end
  // Payload is never cleared outside reset; only the valid bits track occupancy.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      ready_q     <= 1'b1;
      main_v      <= '0;
      skid_v      <= '0;
      main_d      <= '0;
      skid_d      <= '0;
      stall_cnt_o <= '0;
    end else begin
      ready_q     <= state_nx != TWO;
      main_v      <= load_main ? up.valid : skid_to_main ? skid_v : (state_nx == EMPTY) ? '0 : main_v;
      skid_v      <= load_skid ? up.valid : (state_nx == TWO) ? skid_v : '0;
      main_d      <= load_main ? up.data : skid_to_main ? skid_d : main_d;
      skid_d      <= load_skid ? up.data : skid_d;
      stall_cnt_o <= (|main_v && !dn.ready && !flush_i && stall_cnt_o != '1) ? stall_cnt_o + 1'b1 : stall_cnt_o;
    end
endmodule

// File: tb/tb_du_skid_stage.sv
// tb_du_skid_stage: vector table, corner sequences and queue scoreboard for du_skid_stage
module tb_du_skid_stage;
  localparam int WAYS = 2;
  localparam int DW   = 32;
  localparam logic [63:0] A = 64'h0000_00A1_0000_00A0, B = 64'h0000_00B1_0000_00B0;
  localparam logic [63:0] C = 64'h0000_00C1_0000_00C0, D = 64'h0000_00D1_0000_00D0;
  localparam logic [63:0] E = 64'h0000_00E1_0000_00E0, F = 64'h0000_00F1_0000_00F0;
  localparam logic [63:0] G = 64'h0000_0071_0000_0070, H = 64'h0000_0081_0000_0080;
  localparam logic [63:0] X = 64'hDEAD_BEEF_DEAD_BEEF;
  typedef struct {
    logic f; logic [1:0] v; logic [63:0] d; logic r;
    logic [1:0] ev; logic [63:0] ed; logic cd; logic er; logic [1:0] eo; logic [15:0] es;
  } vec_t;
  typedef struct packed {logic [1:0] v; logic [63:0] d;} beat_t;
  logic clk = 1'b0, reset_n = 1'b1, flush = 1'b0;
  logic [1:0] occ;
  logic [15:0] stall;
  int checks = 0, errors = 0;
  vec_t tbl[15];
  beat_t q[$];
  du_skid_stage_if #(.WAYS(WAYS), .DATA_W(DW)) up_if ();
  du_skid_stage_if #(.WAYS(WAYS), .DATA_W(DW)) dn_if ();
  du_skid_stage #(.WAYS(WAYS), .DATA_W(DW), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .flush_i(flush), .up(up_if), .dn(dn_if),
    .occ_o(occ), .stall_cnt_o(stall)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic drive(input logic f, input logic [1:0] v, input logic [63:0] d, input logic r);
    flush = f;
    up_if.valid = v;
    up_if.data = d;
    dn_if.ready = r;
  endtask
  task automatic chk_reset_vals(input string nm);
    chk({nm, "_valid"}, dn_if.valid, 0);
    chk({nm, "_data"}, dn_if.data, 0);
    chk({nm, "_ready"}, up_if.ready, 1);
    chk({nm, "_occ"}, occ, 0);
    chk({nm, "_stall"}, stall, 0);
  endtask
  task automatic pulse_reset();
    @(negedge clk);
    drive(0, 2'b00, X, 0);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask
  initial begin
    tbl[0]  = '{0, 2'b11, A, 1, 2'b11, A, 1, 1, 2'd1, 16'd0};
    tbl[1]  = '{0, 2'b11, B, 1, 2'b11, B, 1, 1, 2'd1, 16'd0};
    tbl[2]  = '{0, 2'b11, C, 1, 2'b11, C, 1, 1, 2'd1, 16'd0};
    tbl[3]  = '{0, 2'b00, X, 1, 2'b00, C, 1, 1, 2'd0, 16'd0};
    tbl[4]  = '{0, 2'b11, A, 0, 2'b11, A, 1, 1, 2'd1, 16'd0};
    tbl[5]  = '{0, 2'b11, B, 0, 2'b11, A, 1, 0, 2'd2, 16'd1};
    tbl[6]  = '{0, 2'b11, D, 0, 2'b11, A, 1, 0, 2'd2, 16'd2};
    tbl[7]  = '{0, 2'b00, X, 1, 2'b11, B, 1, 1, 2'd1, 16'd2};
    tbl[8]  = '{0, 2'b00, X, 1, 2'b00, B, 1, 1, 2'd0, 16'd2};
    tbl[9]  = '{0, 2'b01, E, 0, 2'b01, E, 1, 1, 2'd1, 16'd2};
    tbl[10] = '{0, 2'b10, F, 0, 2'b01, E, 1, 0, 2'd2, 16'd3};
    tbl[11] = '{1, 2'b11, G, 0, 2'b00, X, 0, 1, 2'd0, 16'd3};
    tbl[12] = '{0, 2'b11, H, 1, 2'b11, H, 1, 1, 2'd1, 16'd3};
    tbl[13] = '{0, 2'b00, X, 0, 2'b11, H, 1, 1, 2'd1, 16'd4};
    tbl[14] = '{0, 2'b00, X, 1, 2'b00, H, 1, 1, 2'd0, 16'd4};
    drive(0, 2'b00, X, 0);
    #1 reset_n = 1'b0;
    #2 chk_reset_vals("por");
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      drive(tbl[i].f, tbl[i].v, tbl[i].d, tbl[i].r);
      @(posedge clk);
      #1;
      chk($sformatf("row%0d_valid", i), dn_if.valid, tbl[i].ev);
      if (tbl[i].cd) chk($sformatf("row%0d_data", i), dn_if.data, tbl[i].ed);
      chk($sformatf("row%0d_ready", i), up_if.ready, tbl[i].er);
      chk($sformatf("row%0d_occ", i), occ, tbl[i].eo);
      chk($sformatf("row%0d_stall", i), stall, tbl[i].es);
    end
    @(negedge clk);
    drive(0, 2'b11, A, 0);
    @(negedge clk);
    drive(0, 2'b11, B, 0);
    @(negedge clk);
    drive(0, 2'b00, X, 0);
    chk("pre_async_occ", occ, 2);
    #2 reset_n = 1'b0;
    #1 chk_reset_vals("async");
    @(negedge clk);
    reset_n = 1'b1;
    drive(0, 2'b11, C, 1);
    @(posedge clk);
    #1;
    chk("post_rst_valid", dn_if.valid, 2'b11);
    chk("post_rst_data", dn_if.data, C);
    chk("post_rst_occ", occ, 1);
    pulse_reset();
    begin
      logic [15:0] m_stall;
      m_stall = '0;
      for (int i = 0; i < 10000; i++) begin
        logic f, r, up, dn;
        logic [1:0] v;
        logic [63:0] d;
        @(negedge clk);
        chk("rnd_valid", dn_if.valid, q.size() != 0 ? q[0].v : 2'b00);
        if (q.size() != 0) chk("rnd_data", dn_if.data, q[0].d);
        chk("rnd_ready", up_if.ready, q.size() < 2);
        chk("rnd_occ", occ, q.size());
        chk("rnd_stall", stall, m_stall);
        f = $urandom_range(0, 39) == 0;
        v = 2'($urandom_range(0, 3));
        d = {$urandom, $urandom};
        r = $urandom_range(0, 3) != 0;
        up = |v && q.size() < 2;
        dn = q.size() != 0 && r;
        if (q.size() != 0 && !r && !f && m_stall != 16'hFFFF) m_stall++;
        if (f) q.delete();
        else begin
          if (dn) void'(q.pop_front());
          if (up) q.push_back('{v, d});
        end
        drive(f, v, d, r);
      end
    end
    pulse_reset();
    drive(0, 2'b01, E, 0);
    @(negedge clk);
    drive(0, 2'b00, X, 0);
    repeat (100) @(posedge clk);
    #1 chk("stall_100", stall, 100);
    repeat (69900) @(posedge clk);
    #1;
    chk("stall_sat", stall, 16'hFFFF);
    chk("stall_sat_valid", dn_if.valid, 2'b01);
    chk("stall_sat_data", dn_if.data, E);
    chk("stall_sat_occ", occ, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/du_skid_stage.md
DU_SKID_STAGE -- requirements
Module: du_skid_stage

Interface
REQ-001 Parameter WAYS, default 2: number of issue ways carried per beat (1..4).
REQ-002 Parameter DATA_W, default 256: payload bits per way (rd addr, rd wen, PC, rs1/rs2 data, imm, opcode, funct3/7, shamt, pID packed by caller).
REQ-003 Parameter CNT_W, default 16: width of the stall counter.
REQ-004 clk  in  1  single clock; all state updates on posedge clk.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 flush_i  in  1  pipeline flush from branch/exception unit.
REQ-007 valid_i  in  WAYS  per-way valid of the upstream (decode) beat.
REQ-008 data_i  in  WAYS*DATA_W  upstream payload; way k occupies bits [k*DATA_W +: DATA_W].
REQ-009 ready_o  out  1  stage can accept a beat; driven directly from a flop.
REQ-010 valid_o  out  WAYS  per-way valid toward execute.
REQ-011 data_o  out  WAYS*DATA_W  payload toward execute.
REQ-012 ready_i  in  1  execute accepts the current output beat.
REQ-013 occ_o  out  2  entries held (0, 1 or 2).
REQ-014 stall_cnt_o  out  CNT_W  saturating count of output-stall cycles.

Function
REQ-015 A beat exists when any valid_i bit is 1; upstream transfer occurs when (|valid_i) && ready_o; downstream transfer occurs when (|valid_o) && ready_i.
REQ-016 Storage is a main register (drives valid_o/data_o) plus one skid register; together they form a 2-entry in-order FIFO.
REQ-017 States: EMPTY (occ 0), ONE (main full, skid empty), TWO (both full); occ_o encodes the state.
REQ-018 EMPTY: upstream transfer loads main -> ONE.
REQ-019 ONE: upstream and downstream both transfer -> main reloads from input, stay ONE; upstream only -> input loads skid, go TWO; downstream only -> EMPTY; neither -> hold.
REQ-020 TWO: downstream transfer -> skid moves to main, go ONE; upstream transfer impossible (ready_o=0).
REQ-021 ready_o is 1 in EMPTY and ONE, 0 in TWO; it is a registered output with no combinational path from ready_i.
REQ-022 Latency input->output is exactly 1 cycle when EMPTY or when ONE with downstream transfer; sustained throughput is one beat per cycle with ready_i held high.
REQ-023 Per-way valid bits travel with their payload unchanged; a beat with valid_i partially set (e.g. 2'b01) is stored and presented as-is.
REQ-024 When an entry is empty its valid bits read 0; data_o of an empty main register is don't-care but holds its last value (no clearing of payload).
REQ-025 flush_i=1: next cycle state is EMPTY, valid_o=0, occ_o=0, ready_o=1; any simultaneous upstream beat is discarded; flush takes priority over all transfers.
REQ-026 stall_cnt_o increments by 1 in every cycle with (|valid_o) && !ready_i && !flush_i; saturates at 2^CNT_W-1; never wraps; cleared only by reset.
REQ-027 Beat order is strictly preserved; no beat is duplicated or dropped except by flush.

Reset
REQ-028 On reset_n low, immediately and asynchronously: state EMPTY, valid_o=0, data_o=0, skid contents=0, occ_o=0, ready_o=1, stall_cnt_o=0.
REQ-029 Reset asserted mid-operation (any state) discards all held beats; first cycle after release behaves as EMPTY.

Verification
REQ-030 Reset then valid_i=2'b11, data A, ready_i=1 each cycle with beats A,B,C -> valid_o=2'b11 with A,B,C on consecutive cycles starting 1 cycle after input, ready_o stays 1, occ_o=1.
REQ-031 ready_i=0, send A then B -> after 2 cycles occ_o=2, ready_o=0, data_o=A; raise ready_i -> A, then B next cycle, ready_o returns to 1 one cycle after A leaves.
REQ-032 occ_o=2 and flush_i=1 with valid_i=2'b11 present -> next cycle valid_o=0, occ_o=0, ready_o=1; new beat after flush appears normally.
REQ-033 valid_o=2'b01 held with ready_i=0 for 70000 cycles at CNT_W=16 -> stall_cnt_o stops at 65535.
REQ-034 Random valid_i/ready_i/flush_i over 10000 cycles vs scoreboard -> output sequence equals accepted inputs minus flushed ones, valid_o never drops without transfer or flush.
REQ-035 reset_n pulsed low asynchronously (between edges) while occ_o=2 -> outputs go to reset values before next clk edge.
